// File: rtl/mfp_ahb_gpio_irq_if.sv
// AHB-Lite bus bundle for the GPIO slave: master drives address/control/write data, slave returns read data.
interface mfp_ahb_gpio_irq_if;
  logic [5:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;

  modport master (output HADDR, HTRANS, HWRITE, HSEL, HWDATA, input HRDATA);
  modport slave  (input HADDR, HTRANS, HWRITE, HSEL, HWDATA, output HRDATA);
endinterface

// File: rtl/mfp_ahb_gpio_irq.sv
// Zero-wait-state AHB-Lite GPIO with set/clear/toggle outputs and edge interrupts.
// Optional input debouncer is enabled by defining MFP_GPIO_DEBOUNCE_EN.
module mfp_ahb_gpio_irq #(
  parameter int               N_IN    = 16,
  parameter int               N_OUT   = 16,
  parameter logic [N_OUT-1:0] OUT_RST = '0,
  parameter int               DB_DIV  = 50000
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  mfp_ahb_gpio_irq_if.slave      bus,
  input  logic [N_IN-1:0]        GPIO_IN,
  output logic [N_OUT-1:0]       GPIO_OUT,
  output logic                   IRQ
);

  localparam logic [3:0] A_IN    = 4'd0;
  localparam logic [3:0] A_OUT   = 4'd1;
  localparam logic [3:0] A_SET   = 4'd2;
  localparam logic [3:0] A_CLR   = 4'd3;
  localparam logic [3:0] A_TGL   = 4'd4;
  localparam logic [3:0] A_RISE  = 4'd5;
  localparam logic [3:0] A_FALL  = 4'd6;
  localparam logic [3:0] A_STAT  = 4'd7;
  localparam logic [3:0] A_MASK  = 4'd8;

  logic [3:0]       idx_q;
  logic             hsel_q;
  logic             hwrite_q;
  logic [1:0]       htrans_q;
  logic             we;

  logic [N_IN-1:0]  sync1_q;
  logic [N_IN-1:0]  sync_q;
  logic [N_IN-1:0]  cond_in;
  logic [N_IN-1:0]  prev_q;
  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  fall;
  logic [N_IN-1:0]  set_vec;
  logic [N_IN-1:0]  w1c_vec;

  logic [N_OUT-1:0] out_q;
  logic [N_IN-1:0]  rise_en_q;
  logic [N_IN-1:0]  fall_en_q;
  logic [N_IN-1:0]  stat_q;
  logic [N_IN-1:0]  mask_q;
  logic             irq_q;
  logic [31:0]      hrdata_q;
  logic [31:0]      rd_nxt;

  logic [N_IN-1:0]  wdat_in;
  logic [N_OUT-1:0] wdat_out;
  logic             unused_bits;

  assign wdat_in     = bus.HWDATA[N_IN-1:0];
  assign wdat_out    = bus.HWDATA[N_OUT-1:0];
  assign unused_bits = ^{bus.HADDR[1:0], bus.HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q    <= '0;
      hsel_q   <= 1'b0;
      hwrite_q <= 1'b0;
      htrans_q <= 2'b00;
    end else begin
      idx_q    <= bus.HADDR[5:2];
      hsel_q   <= bus.HSEL;
      hwrite_q <= bus.HWRITE;
      htrans_q <= bus.HTRANS;
    end
  end

  assign we = hsel_q & hwrite_q & (htrans_q != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= GPIO_IN;
      sync_q  <= sync1_q;
    end
  end

`ifdef MFP_GPIO_DEBOUNCE_EN
  localparam int CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

  logic [CW-1:0]   div_q;
  logic            tick;
  logic [N_IN-1:0] sample_q;
  logic [N_IN-1:0] cond_q;

  assign tick = (div_q == CW'(DB_DIV - 1));

  // A bit is accepted only when it matched at two consecutive ticks.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_q    <= '0;
      sample_q <= '0;
      cond_q   <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        sample_q <= sync_q;
        cond_q   <= (sample_q & ~(sample_q ^ sync_q)) | (cond_q & (sample_q ^ sync_q));
      end
    end
  end

  assign cond_in = cond_q;
`else
  assign cond_in = sync_q;
`endif

  assign rise    = cond_in & ~prev_q;
  assign fall    = ~cond_in & prev_q;
  assign set_vec = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c_vec = (we && idx_q == A_STAT) ? wdat_in : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prev_q    <= '0;
      out_q     <= OUT_RST;
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask_q    <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q <= cond_in;
      // A new edge outranks a simultaneous clear so no event is lost.
      stat_q <= (stat_q & ~w1c_vec) | set_vec;
      irq_q  <= |(stat_q & mask_q);
      if (we) begin
        case (idx_q)
          A_OUT:   out_q     <= wdat_out;
          A_SET:   out_q     <= out_q | wdat_out;
          A_CLR:   out_q     <= out_q & ~wdat_out;
          A_TGL:   out_q     <= out_q ^ wdat_out;
          A_RISE:  rise_en_q <= wdat_in;
          A_FALL:  fall_en_q <= wdat_in;
          A_MASK:  mask_q    <= wdat_in;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (bus.HADDR[5:2])
      A_IN:    rd_nxt = 32'(cond_in);
      A_OUT:   rd_nxt = 32'(out_q);
      A_RISE:  rd_nxt = 32'(rise_en_q);
      A_FALL:  rd_nxt = 32'(fall_en_q);
      A_STAT:  rd_nxt = 32'(stat_q);
      A_MASK:  rd_nxt = 32'(mask_q);
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hrdata_q <= '0;
    else          hrdata_q <= rd_nxt;
  end

  assign bus.HRDATA = hrdata_q;
  assign GPIO_OUT   = out_q;
  assign IRQ        = irq_q;

endmodule

// File: tb/tb_mfp_ahb_gpio_irq.sv
// Directed bench for mfp_ahb_gpio_irq: register-access vector table plus interrupt timing sequences.
module tb_mfp_ahb_gpio_irq;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [15:0] GPIO_IN = '0;
  logic [15:0] GPIO_OUT;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  mfp_ahb_gpio_irq_if bus ();

  mfp_ahb_gpio_irq #(.N_IN(16), .N_OUT(16), .OUT_RST(16'h0000), .DB_DIV(8)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .GPIO_IN  (GPIO_IN),
    .GPIO_OUT (GPIO_OUT),
    .IRQ      (IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
    logic        exp_irq;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that commits the write.
  task automatic ahb_write(input logic [5:0] a, input logic [31:0] d);
    bus.HADDR  = a;
    bus.HSEL   = 1'b1;
    bus.HWRITE = 1'b1;
    bus.HTRANS = 2'b10;
    tick(1);
    bus.HWDATA = d;
    bus_idle();
    tick(1);
  endtask

  task automatic ahb_read(input logic [5:0] a, output logic [31:0] rd);
    bus.HADDR  = a;
    bus.HSEL   = 1'b1;
    bus.HWRITE = 1'b0;
    bus.HTRANS = 2'b10;
    tick(1);
    bus_idle();
    rd = bus.HRDATA;
  endtask

  function automatic vec_t mk(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic [15:0] eo);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_out = eo; v.exp_irq = 1'b0;
    return v;
  endfunction

  logic [31:0] rd;

  initial begin
    bus.HADDR  = '0;
    bus.HWDATA = '0;
    bus_idle();

`ifdef MFP_GPIO_DEBOUNCE_EN
    GPIO_IN = 16'h0000;
    tick(3);
    HRESETn = 1'b1;
    tick(4);
    ahb_write(6'h14, 32'h4);
    GPIO_IN[2] = 1'b1;
    tick(5);
    GPIO_IN[2] = 1'b0;
    tick(40);
    ahb_read(6'h00, rd);
    chk("db_glitch_in", rd, 32'h0);
    ahb_read(6'h1C, rd);
    chk("db_glitch_stat", rd, 32'h0);
    GPIO_IN[2] = 1'b1;
    tick(24);
    ahb_read(6'h00, rd);
    chk("db_level_in", rd, 32'h4);
    ahb_read(6'h1C, rd);
    chk("db_level_stat", rd, 32'h4);
`else
    GPIO_IN = 16'hA5A5;
    tick(3);
    chk("rst_out", 32'(GPIO_OUT), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    HRESETn = 1'b1;
    tick(4);

    vecs[0]  = mk(1'b0, 6'h04, 32'h0,        32'h0,    16'h0000);
    vecs[1]  = mk(1'b0, 6'h00, 32'h0,        32'hA5A5, 16'h0000);
    vecs[2]  = mk(1'b1, 6'h04, 32'h00F0,     32'h0,    16'h00F0);
    vecs[3]  = mk(1'b1, 6'h08, 32'h000F,     32'h0,    16'h00FF);
    vecs[4]  = mk(1'b1, 6'h0C, 32'h0030,     32'h0,    16'h00CF);
    vecs[5]  = mk(1'b1, 6'h10, 32'h0101,     32'h0,    16'h01CE);
    vecs[6]  = mk(1'b0, 6'h08, 32'h0,        32'h0,    16'h01CE);
    vecs[7]  = mk(1'b0, 6'h0C, 32'h0,        32'h0,    16'h01CE);
    vecs[8]  = mk(1'b0, 6'h10, 32'h0,        32'h0,    16'h01CE);
    vecs[9]  = mk(1'b0, 6'h04, 32'h0,        32'h01CE, 16'h01CE);
    vecs[10] = mk(1'b1, 6'h24, 32'hFFFF,     32'h0,    16'h01CE);
    vecs[11] = mk(1'b0, 6'h24, 32'h0,        32'h0,    16'h01CE);
    vecs[12] = mk(1'b1, 6'h00, 32'hFFFF,     32'h0,    16'h01CE);
    vecs[13] = mk(1'b0, 6'h00, 32'h0,        32'hA5A5, 16'h01CE);
    vecs[14] = mk(1'b1, 6'h14, 32'h1,        32'h0,    16'h01CE);
    vecs[15] = mk(1'b0, 6'h14, 32'h0,        32'h1,    16'h01CE);
    vecs[16] = mk(1'b0, 6'h1C, 32'h0,        32'h0,    16'h01CE);
    vecs[17] = mk(1'b1, 6'h20, 32'h1,        32'h0,    16'h01CE);
    vecs[18] = mk(1'b0, 6'h20, 32'h0,        32'h1,    16'h01CE);
    vecs[19] = mk(1'b1, 6'h18, 32'hFFFF0008, 32'h0,    16'h01CE);
    vecs[20] = mk(1'b0, 6'h18, 32'h0,        32'h8,    16'h01CE);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) ahb_write(vecs[i].addr, vecs[i].wdata);
      else begin
        ahb_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_out", i), 32'(GPIO_OUT), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_irq", i), 32'(IRQ), 32'(vecs[i].exp_irq));
    end

    // Rising edge on bit 0: IRQ rises on the fourth edge after the pin change.
    GPIO_IN[0] = 1'b0;
    tick(5);
    ahb_read(6'h1C, rd);
    chk("fall0_ignored", rd, 32'h0);
    GPIO_IN[0] = 1'b1;
    tick(3);
    chk("irq_at_3", 32'(IRQ), 32'h0);
    tick(1);
    chk("irq_at_4", 32'(IRQ), 32'h1);
    ahb_read(6'h1C, rd);
    chk("stat_rise0", rd, 32'h1);
    ahb_write(6'h1C, 32'h1);
    chk("irq_after_w1c", 32'(IRQ), 32'h1);
    tick(1);
    chk("irq_cleared", 32'(IRQ), 32'h0);

    // Falling edge on bit 3 with mask off, then unmask.
    GPIO_IN[3] = 1'b1;
    tick(5);
    ahb_write(6'h20, 32'h0);
    GPIO_IN[3] = 1'b0;
    tick(5);
    ahb_read(6'h1C, rd);
    chk("stat_fall3", rd, 32'h8);
    chk("irq_masked", 32'(IRQ), 32'h0);
    ahb_write(6'h20, 32'h8);
    chk("irq_unmask_same", 32'(IRQ), 32'h0);
    tick(1);
    chk("irq_unmask_next", 32'(IRQ), 32'h1);

    // Clear, then land a new fall edge on the same edge as a W1C.
    ahb_write(6'h1C, 32'h8);
    tick(2);
    ahb_read(6'h1C, rd);
    chk("stat_clr3", rd, 32'h0);
    chk("irq_clr3", 32'(IRQ), 32'h0);
    GPIO_IN[3] = 1'b1;
    tick(5);
    GPIO_IN[3] = 1'b0;
    tick(1);
    ahb_write(6'h1C, 32'h8);
    ahb_read(6'h1C, rd);
    chk("set_wins", rd, 32'h8);
    ahb_write(6'h1C, 32'h8);
    ahb_read(6'h1C, rd);
    chk("stat_clr_again", rd, 32'h0);

    // Write followed directly by a read of OUT returns the old value.
    bus.HADDR  = 6'h04;
    bus.HSEL   = 1'b1;
    bus.HWRITE = 1'b1;
    bus.HTRANS = 2'b10;
    tick(1);
    bus.HWDATA = 32'h1234;
    bus.HWRITE = 1'b0;
    tick(1);
    bus_idle();
    chk("no_fwd_rd", bus.HRDATA, 32'h01CE);
    chk("no_fwd_out", 32'(GPIO_OUT), 32'h1234);
    ahb_read(6'h04, rd);
    chk("out_after", rd, 32'h1234);

    // Asynchronous reset mid-operation.
    tick(1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_out", 32'(GPIO_OUT), 32'h0);
    chk("mid_rst_hrdata", bus.HRDATA, 32'h0);
    tick(2);
    HRESETn = 1'b1;
    tick(1);
    ahb_read(6'h14, rd);
    chk("mid_rst_rise_en", rd, 32'h0);
    ahb_read(6'h20, rd);
    chk("mid_rst_mask", rd, 32'h0);
    ahb_read(6'h04, rd);
    chk("mid_rst_out_rd", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
